fft_dif_sequencer: RTL and testbench

- Controls an in-place, radix-2 decimation-in-frequency (DIF) FFT over N = 2^LOG2N complex points held in a dual-port data RAM.
- Once started, it runs all LOG2N stages. For each butterfly it issues the read-address pair (A, B) and the twiddle-ROM index. It then replays the same addresses as write-back strobes, delayed to match the RAM read latency plus the butterfly latency.
- It sits between the top-level FFT control (Start/Done handshake), the data RAM, the cos/sin twiddle ROM, and the butterfly datapath (y0 = x0 + x1; y1 = (x0 - x1)·W).

---
 rtl/fft_dif_sequencer.sv | 124 ++++++++++++
 tb/tb_fft_dif_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fft_dif_sequencer.sv
// fft_dif_sequencer: radix-2 DIF FFT stage/butterfly sequencer with PIPE-delayed write-back strobes.
// Optional FFT_SEQ_BITREV_UNLOAD_EN adds a bit-reversed unload phase (unload_valid/unload_addr) before Done.
module fft_dif_sequencer #(
    parameter int LOG2N      = 3,
    parameter int RD_LATENCY = 1,
    parameter int BF_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    output logic             Done,
    output logic             Busy,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_index,
    output logic [3:0]       stage_idx,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    ,
    output logic             unload_valid,
    output logic [LOG2N-1:0] unload_addr
`endif
);
    localparam int PIPE = RD_LATENCY + BF_LATENCY;
    localparam int DW = $clog2(PIPE + 1);
    localparam int LW = 2 * LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST_J = LOG2N'((1 << (LOG2N - 1)) - 1);
    localparam logic [DW-1:0] LAST_D = DW'(PIPE - 1);
    localparam logic [3:0] LAST_S = 4'(LOG2N - 1);
    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, UNLOAD, DONE} state_t;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    localparam state_t FINAL = UNLOAD;
`else
    localparam state_t FINAL = DONE;
`endif
    state_t state, state_n;
    logic [LOG2N-1:0] cnt, cnt_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [3:0] stage, stage_n;
    logic [LOG2N-1:0] mask, addr_a;
    logic [LW-1:0] dly [PIPE];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dcnt  <= '0;
            stage <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            dcnt  <= dcnt_n;
            stage <= stage_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        stage_n = stage;
        case (state)
            IDLE: begin
                state_n = Start ? ISSUE : IDLE;
                cnt_n   = '0;
                dcnt_n  = '0;
                stage_n = '0;
            end
            ISSUE: begin
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == LAST_J) ? DRAIN : ISSUE;
            end
            DRAIN: begin
                dcnt_n = (dcnt == LAST_D) ? '0 : dcnt + 1'b1;
                if (dcnt == LAST_D) begin
                    cnt_n   = '0;
                    stage_n = stage + 4'd1;
                    state_n = (stage == LAST_S) ? FINAL : ISSUE;
                end
            end
            UNLOAD: begin
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == '1) ? DONE : UNLOAD;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Butterfly j splits into group bits (above mask) and offset k (under mask); a = 2*g*span + k.
    assign mask      = {LOG2N{1'b1}} >> (stage + 4'd1);
    assign addr_a    = ((cnt & ~mask) << 1) | (cnt & mask);
    assign rd_en     = (state == ISSUE);
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? addr_a + (mask + 1'b1) : '0;
    assign tw_index  = rd_en ? (LOG2N-1)'((cnt & mask) << stage) : '0;
    assign stage_idx = rd_en ? stage : '0;
    assign Busy      = (state == ISSUE) || (state == DRAIN) || (state == UNLOAD);
    assign Done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < PIPE; i++) dly[i] <= dly[i-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = dly[PIPE-1];

`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    logic [LOG2N-1:0] rev;
    always_comb begin
        rev = '0;
        for (int i = 0; i < LOG2N; i++) rev[i] = cnt[LOG2N-1-i];
    end
    assign unload_valid = (state == UNLOAD);
    assign unload_addr  = unload_valid ? rev : '0;
`endif
endmodule

// File: tb/tb_fft_dif_sequencer.sv
// tb_fft_dif_sequencer: per-cycle schedule model of the DIF sequencer plus literal pins for N=8, PIPE=2.
module tb_fft_dif_sequencer;
    localparam int LOG2N = 3;
    localparam int N = 1 << LOG2N;
    localparam int HALF = N / 2;
    localparam int RDL = 1;
    localparam int BFL = 1;
    localparam int PIPE = RDL + BFL;
    localparam int L = 64;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    localparam int UNL = N;
`else
    localparam int UNL = 0;
`endif
    localparam int CORE = LOG2N * (HALF + PIPE);
    localparam int RUN = CORE + UNL;

    logic clk = 0;
    logic reset = 1;
    logic Start = 0;
    logic Done, Busy, rd_en, wr_en;
    logic [LOG2N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG2N-2:0] tw_index;
    logic [3:0] stage_idx;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    logic unload_valid;
    logic [LOG2N-1:0] unload_addr;
`endif

    fft_dif_sequencer #(.LOG2N(LOG2N), .RD_LATENCY(RDL), .BF_LATENCY(BFL)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Done(Done), .Busy(Busy),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_index(tw_index), .stage_idx(stage_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
        , .unload_valid(unload_valid), .unload_addr(unload_addr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, scen = 0;
    bit chk_on = 0;
    bit st_in [L], rs_in [L];
    int e_rd [L], e_a [L], e_b [L], e_tw [L], e_st [L];
    int e_wr [L], e_wa [L], e_wb [L], e_busy [L], e_done [L], e_uv [L], e_ua [L];

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) if (((v >> b) & 1) != 0) r |= 1 << (LOG2N - 1 - b);
        return r;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < L; c++) begin
            st_in[c] = 0; rs_in[c] = 0;
            e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_st[c] = 0;
            e_wr[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_uv[c] = 0; e_ua[c] = 0;
        end
    endtask

    // One whole transform whose Start is sampled at the edge closing cycle t0.
    task automatic add_run(input int t0);
        for (int s = 0; s < LOG2N; s++) begin
            int span = N >> (s + 1);
            for (int j = 0; j < HALF; j++) begin
                int c = t0 + 1 + s * (HALF + PIPE) + j;
                int a = (j / span) * 2 * span + (j % span);
                if (c < L) begin
                    e_rd[c] = 1; e_a[c] = a; e_b[c] = a + span; e_tw[c] = (j % span) << s; e_st[c] = s;
                end
                if (c + PIPE < L) begin
                    e_wr[c+PIPE] = 1; e_wa[c+PIPE] = a; e_wb[c+PIPE] = a + span;
                end
            end
        end
        for (int c = t0 + 1; c <= t0 + RUN && c < L; c++) e_busy[c] = 1;
        for (int i = 0; i < UNL; i++) begin
            int c = t0 + CORE + 1 + i;
            if (c < L) begin e_uv[c] = 1; e_ua[c] = bitrev(i); end
        end
        if (t0 + RUN + 1 < L) e_done[t0+RUN+1] = 1;
    endtask

    // A reset sampled at the edge closing cycle r wipes everything from cycle r+1 on.
    task automatic cut_after(input int r);
        for (int c = r + 1; c < L; c++) begin
            e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_st[c] = 0;
            e_wr[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_uv[c] = 0; e_ua[c] = 0;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s scen=%0d cyc=%0d got=%0d expected=%0d", nm, scen, cyc, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        chk("rd_en", rd_en, e_rd[cyc]);
        chk("rd_addr_a", rd_addr_a, e_a[cyc]);
        chk("rd_addr_b", rd_addr_b, e_b[cyc]);
        chk("tw_index", tw_index, e_tw[cyc]);
        chk("stage_idx", stage_idx, e_st[cyc]);
        chk("wr_en", wr_en, e_wr[cyc]);
        chk("wr_addr_a", wr_addr_a, e_wa[cyc]);
        chk("wr_addr_b", wr_addr_b, e_wb[cyc]);
        chk("Busy", Busy, e_busy[cyc]);
        chk("Done", Done, e_done[cyc]);
        chk("busy_done_excl", int'(Busy & Done), 0);
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
        chk("unload_valid", unload_valid, e_uv[cyc]);
        chk("unload_addr", unload_addr, e_ua[cyc]);
`endif
        if (scen == 0) begin
            case (cyc)
                1:  begin chk("pin_c1_a", rd_addr_a, 0); chk("pin_c1_b", rd_addr_b, 4); chk("pin_c1_tw", tw_index, 0); end
                4:  begin chk("pin_c4_a", rd_addr_a, 3); chk("pin_c4_b", rd_addr_b, 7); chk("pin_c4_tw", tw_index, 3); end
                5:  chk("pin_c5_rd_en", rd_en, 0);
                8:  begin chk("pin_c8_a", rd_addr_a, 1); chk("pin_c8_b", rd_addr_b, 3); chk("pin_c8_tw", tw_index, 2); chk("pin_c8_stage", stage_idx, 1); end
                10: begin chk("pin_c10_a", rd_addr_a, 5); chk("pin_c10_b", rd_addr_b, 7); chk("pin_c10_tw", tw_index, 2); end
                15: begin chk("pin_c15_a", rd_addr_a, 4); chk("pin_c15_b", rd_addr_b, 5); chk("pin_c15_stage", stage_idx, 2); end
                18: begin chk("pin_c18_wr_en", wr_en, 1); chk("pin_c18_wa", wr_addr_a, 6); chk("pin_c18_wb", wr_addr_b, 7); chk("pin_c18_busy", Busy, 1); end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
                20: chk("pin_c20_unload_addr", unload_addr, 4);
                27: begin chk("pin_c27_done", Done, 1); chk("pin_c27_busy", Busy, 0); end
`else
                19: begin chk("pin_c19_done", Done, 1); chk("pin_c19_busy", Busy, 0); end
`endif
                default: ;
            endcase
        end
    end

    task automatic run_scen(input int len);
        reset = 1; Start = 0; chk_on = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < len; c++) begin
            cyc = c; reset = rs_in[c]; Start = st_in[c]; chk_on = 1;
            @(posedge clk);
            #1;
        end
        chk_on = 0;
    endtask

    initial begin
        // Single Start pulse, plus a stray Start mid-transform that must be ignored.
        scen = 0; clear_model();
        st_in[0] = 1; st_in[8] = 1;
        add_run(0);
        run_scen(RUN + 8);
        // Start held high: back-to-back transforms, each restarting from the IDLE cycle after Done.
        scen = 1; clear_model();
        for (int c = 0; c < L; c++) st_in[c] = 1;
        add_run(0); add_run(RUN + 2); add_run(2 * RUN + 4);
        run_scen(2 * RUN + 8);
        // Reset mid-run aborts with no stray write-back; a later Start runs cleanly.
        scen = 2; clear_model();
        st_in[0] = 1; rs_in[9] = 1; st_in[12] = 1;
        add_run(0); cut_after(9); add_run(12);
        run_scen(12 + RUN + 4);
        // Start raised only in the Done cycle is not a restart.
        scen = 3; clear_model();
        st_in[0] = 1; st_in[RUN + 1] = 1;
        add_run(0);
        run_scen(RUN + 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
